// File: rtl/fst_io_pkg.sv
// Shared definitions for the core's output-port peripherals.
package fst_io_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is still taken when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/out_uart_tx.sv
// Buffers 16-bit core output-port writes and sends each as two 8N1 UART bytes,
// high byte first, with the two frames joined back to back.
module out_uart_tx
  import fst_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              out_en,
  input  logic [WORD_W-1:0] out_dat,
  input  logic              halting,
  output logic              txd,
  output logic              busy,
  output logic              overflow,
  output logic              drained
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_n;
  logic [15:0]       baud_cnt, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic              low_byte, low_n;
  logic [WORD_W-1:0] word, word_n;
  logic [BYTE_W-1:0] cur_byte;
  logic              txd_n;
  logic              busy_n;
  logic              drained_n;
  logic              bit_end;

  logic              push;
  logic              pop;
  logic              accepted;
  logic              drop;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_n;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (out_dat),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign push     = out_en && !halting;
  assign accepted = push && (!fifo_full || pop);
  assign drop     = push && fifo_full && !pop;
  assign count_n  = fifo_count + CW'(accepted) - CW'(pop);
  assign bit_end  = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 16'd1;
    bit_n   = bit_cnt;
    low_n   = low_byte;
    word_n  = word;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_n  = fifo_dout;
          low_n   = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          // High-byte stop runs straight into the low-byte start bit.
          if (!low_byte) begin
            low_n   = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Line level is decided from the state being entered so txd is a plain flop.
    cur_byte = low_n ? word_n[BYTE_W-1:0] : word_n[WORD_W-1:BYTE_W];
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = cur_byte[bit_n];
      default: txd_n = 1'b1;
    endcase

    busy_n    = (state_n != IDLE) || (count_n != '0);
    drained_n = halting && (state == IDLE) && fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      low_byte <= 1'b0;
      word     <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      drained  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      low_byte <= low_n;
      word     <= word_n;
      txd      <= txd_n;
      busy     <= busy_n;
      drained  <= drained_n;
      overflow <= overflow | drop;
    end
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: word-level transmit model, per-cycle compare, UART receiver
// scoreboard and directed scenarios with hand-computed timing.
module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 20 * CPB;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        out_en   = 1'b0;
  logic        halting  = 1'b0;
  logic [15:0] out_dat  = 16'h0000;
  logic        txd;
  logic        busy;
  logic        overflow;
  logic        drained;

  int checks = 0;
  int errors = 0;

  out_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .out_en   (out_en),
    .out_dat  (out_dat),
    .halting  (halting),
    .txd      (txd),
    .busy     (busy),
    .overflow (overflow),
    .drained  (drained)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  // ---------------- model ----------------
  int          cyc = 0;
  int          rst_cnt = 0;
  logic [15:0] mq[$];
  bit          active = 0;
  bit          was_active;
  bit          m_pop;
  int          size_before;
  int          f0 = 0;
  logic [15:0] cur_w = '0;
  logic        m_txd = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_drained = 1'b0;
  bit          m_valid = 0;

  // Line level t cycles into a 20-bit-time word frame: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [15:0] w, input int t);
    int b;
    int pos;
    logic [7:0] by;
    b   = t / CPB;
    pos = b % 10;
    by  = (b < 10) ? w[15:8] : w[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[pos-1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      mq.delete();
      active    = 0;
      m_txd     = 1'b1;
      m_busy    = 1'b0;
      m_ovf     = 1'b0;
      m_drained = 1'b0;
      m_valid   = 1;
      rst_cnt++;
    end else begin
      was_active  = active;
      size_before = mq.size();
      m_pop       = !was_active && (size_before > 0);
      if (m_pop) begin
        cur_w  = mq.pop_front();
        active = 1;
        f0     = cyc;
      end else if (was_active && (cyc == f0 + FRAME)) begin
        active = 0;
      end
      if (out_en && !halting) begin
        if (size_before < DEPTH || m_pop) mq.push_back(out_dat);
        else m_ovf = 1'b1;
      end
      m_drained = halting && !was_active && (size_before == 0);
      m_busy    = active || (mq.size() > 0);
      m_txd     = active ? frame_bit(cur_w, cyc - f0) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("cyc_txd", {31'd0, txd}, {31'd0, m_txd});
      check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      check("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("cyc_drained", {31'd0, drained}, {31'd0, m_drained});
    end
  end

  // ---------------- receiver / scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] rx_q[$];
  int          rx_rst_seen = 0;
  bit          rx_on = 0;
  bit          have_hi = 0;
  int          rx_n = 0;
  int          bi;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  hi_byte = '0;

  initial forever begin
    @(negedge clk);
    if (rx_rst_seen != rst_cnt) begin
      rx_rst_seen = rst_cnt;
      rx_on       = 0;
      have_hi     = 0;
    end else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on = 1;
        rx_n  = 0;
      end
    end else begin
      rx_n++;
      if (rx_n % CPB == CPB / 2) begin
        bi = rx_n / CPB;
        if (bi >= 1 && bi <= 8) begin
          rx_byte[bi-1] = txd;
        end else if (bi == 9) begin
          check("rx_stop_bit", {31'd0, txd}, 32'd1);
          if (have_hi) begin
            rx_q.push_back({hi_byte, rx_byte});
            have_hi = 0;
          end else begin
            hi_byte = rx_byte;
            have_hi = 1;
          end
          rx_on = 0;
        end
      end
    end
  end

  task automatic check_words(input string name);
    check({name, "_word_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check({name, "_word"}, {16'd0, rx_q[i]}, {16'd0, exp_q[i]});
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic write(input logic [15:0] d);
    out_en  = 1'b1;
    out_dat = d;
    @(negedge clk);
    out_en  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_in_budget"}, {31'd0, n < budget}, 32'd1);
    tick(2);
  endtask

  // ---------------- directed tests ----------------
  logic [19:0] exp_bits;
  logic        samp [120];
  int          p;
  int          fall;
  int          busy_cnt;
  int          lows;
  int          n;

  initial begin
    reset_n = 1'b0;
    tick(3);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drained", {31'd0, drained}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Single word while idle: latency, bit pattern, busy length.
    write(16'hA55A);
    p        = cyc;
    fall     = -1;
    busy_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      samp[i] = txd;
      if (busy === 1'b1) busy_cnt++;
      if (fall < 0 && txd === 1'b0) fall = i;
      @(negedge clk);
    end
    check("t1_fall_latency", fall, 32'd1);
    check("t1_busy_cycles", busy_cnt, 32'd81);
    exp_bits = 20'b0101001011_0010110101;
    for (int i = 0; i < 20; i++) begin
      check("t1_serial_bit", {31'd0, samp[1 + i * CPB + CPB / 2]}, {31'd0, exp_bits[19-i]});
    end
    exp_q.push_back(16'hA55A);
    wait_idle("t1", 50);
    check_words("t1");

    // Six back-to-back writes into a depth-4 buffer.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      out_en  = 1'b1;
      out_dat = 16'(i);
      @(negedge clk);
      if (i == 5) check("t2_ovf_before_6th", {31'd0, overflow}, 32'd0);
      if (i == 6) check("t2_ovf_after_6th", {31'd0, overflow}, 32'd1);
    end
    out_en = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(16'(i));
    wait_idle("t2", 600);
    check_words("t2");
    check("t2_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Write on the edge the FSM pops a full buffer.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      write(16'h0100 + 16'(i));
      if (i == 1) p = cyc;
    end
    n = 0;
    while (cyc < p + 81 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_align", cyc - p, 32'd81);
    write(16'h0106);
    check("t3_restart_low", {31'd0, txd}, 32'd0);
    check("t3_no_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 1; i <= 6; i++) exp_q.push_back(16'h0100 + 16'(i));
    wait_idle("t3", 700);
    check_words("t3");
    check("t3_no_overflow_end", {31'd0, overflow}, 32'd0);

    // Reset in the middle of the low-byte data bits.
    do_reset();
    write(16'hFF00);
    p = cyc;
    while (cyc < p + 55) @(negedge clk);
    check("t4_mid_frame", {31'd0, txd}, 32'd0);
    do_reset();
    check("t4_rst_txd", {31'd0, txd}, 32'd1);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    check("t4_no_frame", lows, 32'd0);
    check_words("t4");

    // Halt with two words queued; further writes ignored.
    do_reset();
    write(16'h1234);
    p = cyc;
    write(16'h5678);
    halting = 1'b1;
    check("t5_not_drained_yet", {31'd0, drained}, 32'd0);
    out_en  = 1'b1;
    out_dat = 16'hDEAD;
    tick(3);
    out_en  = 1'b0;
    n = 0;
    while (drained !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t5_drained_cycle", cyc - p, 32'd163);
    check("t5_busy_low", {31'd0, busy}, 32'd0);
    check("t5_no_overflow", {31'd0, overflow}, 32'd0);
    tick(5);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    check_words("t5");
    halting = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
